// File: rtl/mem_resp_pkg.sv
// Shared types for the data-memory responder: FSM states, operation
// encoding and the default word-index width.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OP_LD_W = 2'd0,
      OP_LD_B = 2'd1,
      OP_ST_W = 2'd2,
      OP_ST_B = 2'd3
   } op_e;

   localparam int DEFAULT_DEPTH = 256;
   localparam int DEFAULT_IDX_W = $clog2(DEFAULT_DEPTH);

   // A word store outranks a byte store; byte_load only matters for loads.
   function automatic op_e decodeOp(input logic wordWe, input logic byteWe, input logic byteLoad);
      if (wordWe) return OP_ST_W;
      if (byteWe) return OP_ST_B;
      return byteLoad ? OP_LD_B : OP_LD_W;
   endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane helper: merges a store byte into a word and
// extracts a sign-extended byte for byte loads.
module byte_lane_unit (
   input  logic [63:0] word_i,
   input  logic [2:0]  lane_i,
   input  logic [7:0]  byte_i,
   output logic [63:0] merged_o,
   output logic [63:0] sext_o
);

   logic [7:0] picked;

   always_comb begin
      merged_o = word_i;
      merged_o[{lane_i, 3'b000} +: 8] = byte_i;
      picked = word_i[{lane_i, 3'b000} +: 8];
      sext_o = {{56{picked[7]}}, picked};
   end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder over valid/ready handshakes.
// Optional macro MEM_ALIGN_CHECK_EN faults misaligned word accesses.
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH   = DEFAULT_DEPTH,
   parameter int LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic        req_word_we,
   input  logic        req_byte_we,
   input  logic        req_byte_load,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_data,
   output logic        resp_err,
   output logic        busy
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [63:0]        addr_q;
   logic [63:0]        wdata_q;
   op_e                op_q;
   logic [63:0]        respData_q;
   logic               respErr_q;
   logic [63:0]        mem_q [DEPTH];

   logic               accept;
   logic               commit;
   logic [63:0]        accAddr;
   logic [63:0]        accWdata;
   op_e                accOp;
   logic [IDX_W-1:0]   idx;
   logic               outOfRange;
   logic               misaligned;
   logic               fault;
   logic               isStore;
   logic [63:0]        oldWord;
   logic [63:0]        mergedWord;
   logic [63:0]        laneByte;
   logic [63:0]        respData_d;
   logic [63:0]        memWord_d;

   assign accept = (state_q == IDLE) && req_valid;
   assign commit = (LATENCY == 1) ? accept : ((state_q == WAIT) && (cnt_q == CNT_W'(1)));

   // With LATENCY==1 the commit edge is the accept edge, so the live request is used.
   always_comb begin
      accAddr  = addr_q;
      accWdata = wdata_q;
      accOp    = op_q;
      if (state_q == IDLE) begin
         accAddr  = req_addr;
         accWdata = req_wdata;
         accOp    = decodeOp(req_word_we, req_byte_we, req_byte_load);
      end
   end

   assign idx        = accAddr[IDX_W+2:3];
   assign outOfRange = |accAddr[63:IDX_W+3];
`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = ((accOp == OP_LD_W) || (accOp == OP_ST_W)) && (accAddr[2:0] != 3'd0);
`else
   assign misaligned = 1'b0;
`endif
   assign fault   = outOfRange || misaligned;
   assign isStore = (accOp == OP_ST_W) || (accOp == OP_ST_B);
   assign oldWord = mem_q[idx];

   byte_lane_unit u_lane (
      .word_i   (oldWord),
      .lane_i   (accAddr[2:0]),
      .byte_i   (accWdata[7:0]),
      .merged_o (mergedWord),
      .sext_o   (laneByte)
   );

   always_comb begin
      respData_d = oldWord;
      if (accOp == OP_LD_B) respData_d = laneByte;
      if (fault) respData_d = '0;
      memWord_d = (accOp == OP_ST_B) ? mergedWord : accWdata;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         op_q       <= OP_LD_W;
         respData_q <= '0;
         respErr_q  <= 1'b0;
      end else begin
         if (commit) begin
            respData_q <= respData_d;
            respErr_q  <= fault;
         end
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  op_q    <= decodeOp(req_word_we, req_byte_we, req_byte_load);
                  if (LATENCY == 1) begin
                     state_q <= RESP;
                  end else begin
                     cnt_q   <= CNT_W'(LATENCY - 1);
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) state_q <= RESP;
            end
            RESP: begin
               if (resp_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Faulted requests never write; reset wipes the whole array.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (commit && isStore && !fault) begin
         mem_q[idx] <= memWord_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign busy       = (state_q != IDLE);
   assign resp_data  = respData_q;
   assign resp_err   = respErr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_data_mem_responder;

   localparam int DEPTH   = 256;
   localparam int LATENCY = 2;
   localparam int IDX_W   = $clog2(DEPTH);

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        req_word_we = 1'b0;
   logic        req_byte_we = 1'b0;
   logic        req_byte_load = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [63:0] resp_data;
   logic        resp_err;
   logic        busy;

   always #5 clock = ~clock;

   data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_word_we   (req_word_we),
      .req_byte_we   (req_byte_we),
      .req_byte_load (req_byte_load),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_data     (resp_data),
      .resp_err      (resp_err),
      .busy          (busy)
   );

   int nChecks = 0;
   int nFails  = 0;
   bit checkOn = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
      end
   endtask

   task automatic reportTimeout(input string name);
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s: no DUT event within the cycle bound", name);
   endtask

   // Behavioural model: the whole access is resolved at accept time, since
   // requests never overlap and reset also wipes the array.
   typedef struct packed {
      logic [63:0] data;
      logic        err;
      logic        write;
      logic [63:0] newWord;
   } modelRes_t;

   function automatic modelRes_t modelAccess(input logic [63:0] oldW, input logic [63:0] addr,
                                             input logic [63:0] wdata, input logic wWe,
                                             input logic bWe, input logic bLd);
      modelRes_t r;
      int        sh;
      logic [7:0] b;
      logic      bad;
      r   = '0;
      sh  = int'(addr % 64'd8) * 8;
      bad = (addr >= 64'(DEPTH) * 64'd8);
`ifdef MEM_ALIGN_CHECK_EN
      if ((wWe || (!bWe && !bLd)) && (addr % 64'd8 != 64'd0)) bad = 1'b1;
`endif
      if (bad) begin
         r.err = 1'b1;
         return r;
      end
      b = 8'(oldW >> sh);
      if (wWe) begin
         r.data = oldW;  r.write = 1'b1;  r.newWord = wdata;
      end else if (bWe) begin
         r.data = oldW;  r.write = 1'b1;
         r.newWord = (oldW & ~(64'hFF << sh)) | (64'(wdata[7:0]) << sh);
      end else if (bLd) begin
         r.data = 64'(longint'($signed(b)));
      end else begin
         r.data = oldW;
      end
      return r;
   endfunction

   logic [63:0] mdl [DEPTH];
   logic        mBusy = 1'b0;
   int          cycle = 0;
   int          mAcc  = 0;
   logic [63:0] mData = '0;
   logic        mErr  = 1'b0;
   logic        mRespValid;
   modelRes_t   mRes;

   assign mRes = modelAccess(mdl[req_addr[IDX_W+2:3]], req_addr, req_wdata,
                             req_word_we, req_byte_we, req_byte_load);
   assign mRespValid = mBusy && ((cycle - mAcc) >= LATENCY);

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mBusy <= 1'b0;
         mData <= '0;
         mErr  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mdl[i] <= '0;
      end else begin
         cycle <= cycle + 1;
         if (!mBusy && req_valid) begin
            mBusy <= 1'b1;
            mAcc  <= cycle;
            mData <= mRes.data;
            mErr  <= mRes.err;
            if (mRes.write) mdl[req_addr[IDX_W+2:3]] <= mRes.newWord;
         end else if (mRespValid && resp_ready) begin
            mBusy <= 1'b0;
         end
      end
   end

   // Compare process: handshake/status every cycle, payload whenever a response is due.
   always @(negedge clock) begin
      if (checkOn && !reset) begin
         checkOutput("req_ready", 64'(req_ready), 64'(!mBusy));
         checkOutput("busy", 64'(busy), 64'(mBusy));
         checkOutput("resp_valid", 64'(resp_valid), 64'(mRespValid));
         if (mRespValid) begin
            checkOutput("resp_data", resp_data, mData);
            checkOutput("resp_err", 64'(resp_err), 64'(mErr));
         end
      end
   end

   task automatic applyStimulus(input logic [63:0] addr, input logic [63:0] wdata,
                                input logic wWe, input logic bWe, input logic bLd,
                                input bit randReady, output logic [63:0] data,
                                output logic err, output int lat);
      int waitCnt;
      @(posedge clock); #1;
      req_addr = addr;  req_wdata = wdata;
      req_word_we = wWe;  req_byte_we = bWe;  req_byte_load = bLd;
      req_valid = 1'b1;
      waitCnt = 0;
      do begin
         @(negedge clock);
         waitCnt++;
      end while (!req_ready && waitCnt < 50);
      if (!req_ready) reportTimeout("accept");
      @(posedge clock); #1;
      req_valid = 1'b0;
      req_addr = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      req_word_we = 1'($urandom_range(0, 1));
      req_byte_we = 1'($urandom_range(0, 1));
      req_byte_load = 1'($urandom_range(0, 1));
      resp_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!resp_valid && lat < 50);
      if (!resp_valid) reportTimeout("response");
      data = resp_data;
      err  = resp_err;
      waitCnt = 0;
      while (!resp_ready) begin
         @(posedge clock); #1;
         waitCnt++;
         resp_ready = (waitCnt > 6) ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge clock);
      end
   endtask

   logic [63:0] d;
   logic        e;
   int          lat;
   logic [63:0] held;
   int          bound;

   initial begin
      #1 reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checkOutput("reset req_ready", 64'(req_ready), 64'd1);
      checkOutput("reset resp_valid", 64'(resp_valid), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset resp_data", resp_data, 64'd0);
      checkOutput("reset resp_err", 64'(resp_err), 64'd0);
      checkOn = 1'b1;

      applyStimulus(64'h10, 64'h0, 0, 0, 0, 0, d, e, lat);
      checkOutput("load 0x10 data", d, 64'h0);
      checkOutput("load 0x10 latency", 64'(lat), 64'(LATENCY));

      applyStimulus(64'h8, 64'hDEADBEEF_01234567, 1, 0, 0, 0, d, e, lat);
      checkOutput("store 0x8 old data", d, 64'h0);
      applyStimulus(64'h8, 64'h0, 0, 0, 0, 0, d, e, lat);
      checkOutput("load 0x8 after word store", d, 64'hDEADBEEF_01234567);

      applyStimulus(64'hB, 64'h12345678_9ABCDE80, 0, 1, 0, 0, d, e, lat);
      checkOutput("byte store old data", d, 64'hDEADBEEF_01234567);
      applyStimulus(64'h8, 64'h0, 0, 0, 0, 0, d, e, lat);
      checkOutput("load 0x8 after byte store", d, 64'hDEADBEEF_80234567);
      applyStimulus(64'hB, 64'h0, 0, 0, 1, 0, d, e, lat);
      checkOutput("byte load 0xB", d, 64'hFFFFFFFF_FFFFFF80);
      applyStimulus(64'hC, 64'h0, 0, 0, 1, 0, d, e, lat);
      checkOutput("byte load 0xC", d, 64'hFFFFFFFF_FFFFFFEF);

      // Backpressure: response held five cycles while a second request waits.
      @(posedge clock); #1;
      req_addr = 64'h8;  req_word_we = 0;  req_byte_we = 0;  req_byte_load = 0;
      req_valid = 1'b1;  resp_ready = 1'b0;
      @(posedge clock); #1;
      req_valid = 1'b0;
      bound = 0;
      do begin @(negedge clock); bound++; end while (!resp_valid && bound < 50);
      if (!resp_valid) reportTimeout("backpressure response");
      held = resp_data;
      checkOutput("backpressure data", held, 64'hDEADBEEF_80234567);
      for (int k = 0; k < 5; k++) begin
         @(posedge clock); #1;
         if (k == 0) begin
            req_addr = 64'hB;  req_byte_load = 1'b1;  req_valid = 1'b1;
         end
         @(negedge clock);
         checkOutput("held resp_valid", 64'(resp_valid), 64'd1);
         checkOutput("held resp_data", resp_data, held);
         checkOutput("held req_ready", 64'(req_ready), 64'd0);
      end
      @(posedge clock); #1;
      resp_ready = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      checkOutput("post-handshake req_ready", 64'(req_ready), 64'd1);
      checkOutput("post-handshake resp_valid", 64'(resp_valid), 64'd0);
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat = 0;
      do begin @(negedge clock); lat++; end while (!resp_valid && lat < 50);
      checkOutput("queued byte load", resp_data, 64'hFFFFFFFF_FFFFFF80);
      checkOutput("queued latency", 64'(lat), 64'(LATENCY));

      applyStimulus(64'h0, 64'h11111111_11111111, 1, 0, 0, 0, d, e, lat);
      applyStimulus(64'(DEPTH * 8 - 8), 64'h22222222_22222222, 1, 0, 0, 0, d, e, lat);
      applyStimulus(64'(DEPTH * 8), 64'h33333333_33333333, 1, 0, 0, 0, d, e, lat);
      checkOutput("out-of-range err", 64'(e), 64'd1);
      checkOutput("out-of-range data", d, 64'h0);
      applyStimulus(64'h0, 64'h0, 0, 0, 0, 0, d, e, lat);
      checkOutput("word 0 intact", d, 64'h11111111_11111111);
      applyStimulus(64'(DEPTH * 8 - 8), 64'h0, 0, 0, 0, 0, d, e, lat);
      checkOutput("last word intact", d, 64'h22222222_22222222);

      // Reset while the store is still waiting out its latency.
      @(posedge clock); #1;
      req_addr = 64'h18;  req_wdata = 64'h55555555_55555555;
      req_word_we = 1'b1;  req_byte_load = 1'b0;  req_valid = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;  req_word_we = 1'b0;
      @(negedge clock); #1;
      reset = 1'b1;
      #1;
      checkOutput("reset-in-wait resp_valid", 64'(resp_valid), 64'd0);
      checkOutput("reset-in-wait busy", 64'(busy), 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (3) begin
         @(negedge clock);
         checkOutput("no response after reset", 64'(resp_valid), 64'd0);
      end
      applyStimulus(64'h18, 64'h0, 0, 0, 0, 0, d, e, lat);
      checkOutput("dropped store", d, 64'h0);

      applyStimulus(64'h18, 64'h01234567_89ABCDEF, 1, 0, 0, 0, d, e, lat);
      applyStimulus(64'h1C, 64'h0, 0, 0, 0, 0, d, e, lat);
`ifdef MEM_ALIGN_CHECK_EN
      checkOutput("misaligned load err", 64'(e), 64'd1);
      checkOutput("misaligned load data", d, 64'h0);
`else
      checkOutput("misaligned load err", 64'(e), 64'd0);
      checkOutput("misaligned load data", d, 64'h01234567_89ABCDEF);
`endif

      for (int n = 0; n < 400; n++) begin
         logic [63:0] a;
         int          r;
         r = $urandom_range(0, 9);
         if (r == 0)      a = {$urandom, $urandom};
         else if (r < 3)  a = 64'($urandom_range(0, DEPTH * 8 - 1));
         else             a = 64'($urandom_range(0, 16 * 8 - 1));
         applyStimulus(a, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, d, e, lat);
      end

      repeat (3) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's data-memory port.
- Accepts load/store requests over a valid/ready handshake, holds them for a fixed access latency, then commits them to an internal 64-bit word array.
- Returns exactly one response per accepted request.
- Replaces the zero-latency data memory, so the core can be run against realistic multi-cycle memory timing.

Parameters:
- DEPTH, 256, number of 64-bit words in the array; power of two.
- LATENCY, 2, cycles from request accept to resp_valid assertion; must be >= 1.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state including the array
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_addr  input  64  byte address
- req_wdata  input  64  store data; byte store uses bits [7:0]
- req_word_we  input  1  64-bit store
- req_byte_we  input  1  byte store
- req_byte_load  input  1  sign-extended byte load; ignored on stores
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_data  output  64  load result; old word contents for stores
- resp_err  output  1  request faulted; no array change
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset values:
  - req_ready=1, resp_valid=0, resp_data=0, resp_err=0, busy=0
  - state=IDLE, latency counter=0, all array words=0
- Operation decode:
  - word_we has priority over byte_we.
  - Neither set means a load; byte_load selects byte or word load.
- Addressing:
  - Word index = req_addr[log2(DEPTH)+2:3].
  - Lane = req_addr[2:0].
  - req_addr >= DEPTH*8 sets resp_err=1, resp_data=0, and leaves the array unchanged.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr, wdata and op.
  - If LATENCY==1, go to RESP and perform the access on that edge.
  - Otherwise load counter=LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When the counter is 1, the next edge performs the access, registers resp_data and resp_err, and enters RESP.
- RESP:
  - resp_valid=1; data and err are held stable until the resp_valid&&resp_ready edge, then return to IDLE.
  - With resp_ready tied high, the response lasts 1 cycle.
- Access is performed exactly once, on the edge entering RESP:
  - Word store: array[idx]=wdata.
  - Byte store: only byte lane (addr[2:0]) is replaced by wdata[7:0]; the other 7 bytes are preserved.
  - Word load: resp_data=array[idx].
  - Byte load: resp_data = sign-extend(byte at lane).
  - Stores: resp_data = pre-store array[idx].
- Timing:
  - Latency from accept edge to resp_valid = LATENCY cycles.
  - No overlap between requests; minimum spacing between accepts = LATENCY+1 cycles.
- Request changes: changes to req_* inputs after acceptance are ignored.
- Reset mid-operation:
  - Reset asserted in WAIT drops the request with no commit.
  - Reset asserted in RESP drops the response; the already-committed store stays committed until the array clear, which is also caused by reset.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A word load or word store with req_addr[2:0]!=0 responds with resp_err=1, resp_data=0 and no array write.
  - Byte accesses are unaffected.
- Undefined: addr[2:0] is ignored for word accesses, and the access uses the aligned word.

Decomposition:
- Package mem_resp_pkg:
  - State enum: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Op encoding: OP_LD_W, OP_LD_B, OP_ST_W, OP_ST_B.
  - Localparam for the word-index width.
- One sub-module, byte_lane_unit, combinational:
  - Inputs: word, lane, store byte.
  - Outputs: merged word (byte store) and sign-extended extracted byte (byte load).
  - Instantiated once, at the commit point.

Test Plan:
- Reset then idle:
  - req_ready=1, resp_valid=0, busy=0.
  - Word load addr 0x10 returns 0 after exactly 2 cycles (LATENCY=2).
- Word store:
  - Word store 0xDEADBEEF_01234567 to addr 0x8, then word load 0x8 returns 0xDEADBEEF_01234567.
  - The store's response carries the old value 0.
- Byte store and byte loads:
  - Byte store 0x80 to addr 0xB over the above word; word load 0x8 returns 0xDEADBEEF_80234567.
  - Byte load 0xB returns 0xFFFFFFFF_FFFFFF80.
  - Byte load 0xC returns 0xFFFFFFFF_FFFFFFEF.
- Backpressure:
  - Hold resp_ready=0 for 5 cycles: resp_valid and resp_data stay stable and req_ready stays 0.
  - A new req_valid during this window is not accepted until the cycle after the response handshake.
- Out-of-range address: word store to addr DEPTH*8 gives resp_err=1, resp_data=0, and array contents are unchanged (spot-check words 0 and DEPTH-1).
- Reset and alignment:
  - Assert reset during WAIT of a word store to 0x18: no response is produced and load 0x18 afterwards returns 0.
  - With MEM_ALIGN_CHECK_EN, word load 0x1C gives resp_err=1; without it, it returns the word at 0x18.
